// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared state encoding and default sizing for the CPU output stream path.
package cpu_io_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
    localparam int DEF_WIDTH = 24;
    localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/out_fifo.sv
// out_fifo: synchronous FIFO with occupancy count; head word is shown combinationally, zero when empty.
module out_fifo
    import cpu_io_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/out_stream_ctrl.sv
// out_stream_ctrl: captures CPU output strobes into a FIFO and streams them to the host
// over a valid/ready handshake, with registered stall, sticky overflow and a word counter.
module out_stream_ctrl
    import cpu_io_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             startIO,
    input  logic             outFlag,
    input  logic [WIDTH-1:0] out,
    output logic             io_valid,
    output logic [WIDTH-1:0] io_data,
    input  logic             io_ready,
    output logic             cpu_stall,
    output logic             overflow,
    output logic [15:0]      word_count,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t state, next_state;
    logic full, empty, pop, push, drop, strobe;
    logic [CW-1:0] count, next_count;

    out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(out),
        .rdata(io_data),
        .full (full),
        .empty(empty),
        .count(count)
    );

    assign io_valid   = !empty;
    assign pop        = io_valid && io_ready;
    assign strobe     = state == CAPTURE && outFlag;
    // A full buffer still takes the word if the host frees a slot this cycle.
    assign push       = strobe && (!full || pop);
    assign drop       = strobe && full && !pop;
    assign next_count = count + CW'(push) - CW'(pop);
    assign busy       = state != IDLE;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = startIO ? CAPTURE : IDLE;
            CAPTURE: next_state = startIO ? CAPTURE : DRAIN;
            DRAIN:   next_state = startIO ? CAPTURE : (empty ? IDLE : DRAIN);
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_stall  <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= next_state;
            cpu_stall  <= next_count >= CW'(DEPTH - 1);
            overflow   <= overflow | drop;
            word_count <= word_count + 16'(push);
        end
    end
endmodule

// File: doc/out_stream_ctrl.md
OUT_STREAM_CTRL -- requirements
Module: out_stream_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning CPU output word width.
REQ-002 SHALL have parameter DEPTH, default 8 (power of two), meaning buffer entries.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clock, in, 1, rising-edge system clock.
REQ-005 SHALL have port reset, in, 1, asynchronous active-low reset.
REQ-006 SHALL have port startIO, in, 1, level-sensitive enable for output streaming.
REQ-007 SHALL have port outFlag, in, 1, one-cycle strobe marking CPU word valid on out.
REQ-008 SHALL have port out, in, WIDTH, CPU output word.
REQ-009 SHALL have port io_valid, out, 1, host-side word available.
REQ-010 SHALL have port io_data, out, WIDTH, host-side word (head of buffer).
REQ-011 SHALL have port io_ready, in, 1, host accepts word when high with io_valid.
REQ-012 SHALL have port cpu_stall, out, 1, registered backpressure to CPU.
REQ-013 SHALL have port overflow, out, 1, sticky flag for dropped word.
REQ-014 SHALL have port word_count, out, 16, count of words accepted into the buffer.
REQ-015 SHALL have port busy, out, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, DRAIN.
REQ-017 IDLE -> CAPTURE when startIO=1; outFlag ignored in IDLE (no push, no overflow).
REQ-018 CAPTURE: push out when outFlag=1 and buffer accepts; CAPTURE -> DRAIN when startIO=0.
REQ-019 DRAIN: no pushes; DRAIN -> IDLE when buffer empty; DRAIN -> CAPTURE if startIO=1 again.
REQ-020 Buffer accepts a push when count<DEPTH, or count=DEPTH and a pop occurs same cycle.
REQ-021 Push refused in CAPTURE (full, no pop) SHALL drop the word and set overflow next edge.
REQ-022 overflow SHALL stay set until reset.
REQ-023 Pop occurs when io_valid=1 and io_ready=1; io_valid = (count>0).
REQ-024 Latency: word pushed at edge N SHALL be on io_data with io_valid at N+1 if buffer was empty.
REQ-025 Order SHALL be strict FIFO; io_data SHALL hold stable while io_valid=1 and io_ready=0.
REQ-026 Simultaneous push and pop on empty buffer: pop disabled (io_valid=0), push stored.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-028 cpu_stall SHALL be registered high when next-cycle count >= DEPTH-1, low otherwise.
REQ-029 word_count SHALL increment by 1 per accepted push, wrap 0xFFFF -> 0x0000.
REQ-030 startIO falling in same cycle as outFlag SHALL still push that word (state CAPTURE evaluated).

Reset
REQ-031 reset low SHALL asynchronously force state IDLE, pointers/count 0, io_valid 0, io_data 0, cpu_stall 0, overflow 0, word_count 0, busy 0.
REQ-032 reset asserted mid-stream SHALL discard all buffered words; no io_valid for one cycle after release.
REQ-033 Deassertion SHALL be sampled on clock; first transition earliest one edge after release.

Structure
REQ-034 Package cpu_io_pkg SHALL hold state enum (IDLE, CAPTURE, DRAIN) and default WIDTH/DEPTH constants.
REQ-035 Buffer SHALL be sub-module out_fifo (sync FIFO: push, pop, full, empty, count).
REQ-036 FSM, stall, overflow and word_count logic SHALL reside in out_stream_ctrl.

Verification
REQ-037 startIO=0, outFlag pulses with out=0x00000A -> io_valid stays 0, word_count 0, overflow 0.
REQ-038 startIO=1, push 0x000001,0x000002,0x000003, io_ready=1 -> io_data 1,2,3 in order, each one cycle after push.
REQ-039 io_ready=0, push 9 words 0x000010..0x000018 (DEPTH 8) -> cpu_stall high after 7th, overflow set on 9th, word_count 8, drain yields 0x10..0x17.
REQ-040 Full buffer, push 0x0000AA with io_ready=1 same cycle -> push accepted, overflow stays 0.
REQ-041 Drop startIO with 3 words buffered -> DRAIN, busy=1 until 3 pops, then IDLE, busy=0.
REQ-042 Assert reset with 5 words buffered -> io_valid=0, word_count=0, overflow=0 immediately, state IDLE.
